gray_rx_decoder: RTL and testbench

Receiving end of the Gray-coded count interface driven by the 3-bit Gray counter.
- Samples a Gray-coded word qualified by a valid strobe and converts it to binary with one cycle of latency.
- Tracks the previous sample and classifies each step as up, down, hold or illegal.
- Reports direction and wrap-around, and keeps a saturating count of illegal steps.
- Sits downstream of any Gray counter or clock-domain-crossing pointer for monitoring and decode.

---
 rtl/gray_rx_decoder.sv | 110 +++++++++++
 tb/tb_gray_rx_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gray_rx_decoder.sv
// Gray-code receive monitor: decodes a valid-qualified Gray word and classifies each step.
// Outputs register one cycle after the accepting edge; no backpressure, every valid sample is taken.
module gray_rx_decoder #(
  parameter int WIDTH     = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 gray_valid,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 dir_up,
  output logic                 step_err,
  output logic                 wrap_pulse,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCKED = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_ref;
  logic [WIDTH-1:0]     r_bin;
  logic                 r_bin_valid;
  logic                 r_dir_up;
  logic                 r_step_err;
  logic                 r_wrap;
  logic                 r_locked;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic [WIDTH-1:0]     w_bin;
  logic                 w_acc;
  logic [WIDTH-1:0]     w_delta;
  logic                 w_up;
  logic                 w_down;
  logic                 w_hold;
  logic                 w_wrap;

  // Running XOR from the MSB down gives each binary bit.
  always_comb begin
    w_acc = 1'b0;
    w_bin = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_acc    = w_acc ^ gray_in[i];
      w_bin[i] = w_acc;
    end
  end

  assign w_delta = w_bin - r_ref;
  assign w_up    = (w_delta == WIDTH'(1));
  assign w_down  = (w_delta == '1);
  assign w_hold  = (w_delta == '0);
  assign w_wrap  = (w_up && (r_ref == '1)) || (w_down && (r_ref == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ref       <= '0;
      r_bin       <= '0;
      r_bin_valid <= 1'b0;
      r_dir_up    <= 1'b1;
      r_step_err  <= 1'b0;
      r_wrap      <= 1'b0;
      r_locked    <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_bin_valid <= 1'b0;
      r_step_err  <= 1'b0;
      r_wrap      <= 1'b0;
      if (gray_valid) begin
        r_bin       <= w_bin;
        r_bin_valid <= 1'b1;
        r_ref       <= w_bin;
        case (r_state)
          S_LOCKED: begin
            if (w_up || w_down || w_hold) begin
              if (w_up)   r_dir_up <= 1'b1;
              if (w_down) r_dir_up <= 1'b0;
              r_wrap <= w_wrap;
            end else begin
              r_step_err <= 1'b1;
              if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
              r_state    <= S_ERROR;
              r_locked   <= 1'b0;
            end
          end
          default: begin
            // IDLE and ERROR both (re)acquire the reference without checking.
            r_state  <= S_LOCKED;
            r_locked <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bin_out    = r_bin;
  assign bin_valid  = r_bin_valid;
  assign dir_up     = r_dir_up;
  assign step_err   = r_step_err;
  assign wrap_pulse = r_wrap;
  assign locked     = r_locked;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed plus random stimulus for gray_rx_decoder against a behavioural step model.
module tb_gray_rx_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gray_valid = 1'b0;
  logic [2:0] gray_in = 3'b000;

  logic [2:0] bin_out_a, bin_out_b;
  logic       bin_valid_a, bin_valid_b, dir_up_a, dir_up_b;
  logic       step_err_a, step_err_b, wrap_a, wrap_b, locked_a, locked_b;
  logic [7:0] err_count_a;
  logic [1:0] err_count_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_bin, m_ref, m_cnt, m_cnt2;
  bit m_bv, m_dir, m_err, m_wrap, m_lock;

  always #5 clk = ~clk;

  gray_rx_decoder #(.WIDTH(3), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
    .bin_out(bin_out_a), .bin_valid(bin_valid_a), .dir_up(dir_up_a),
    .step_err(step_err_a), .wrap_pulse(wrap_a), .locked(locked_a),
    .err_count(err_count_a)
  );

  gray_rx_decoder #(.WIDTH(3), .ERR_CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
    .bin_out(bin_out_b), .bin_valid(bin_valid_b), .dir_up(dir_up_b),
    .step_err(step_err_b), .wrap_pulse(wrap_b), .locked(locked_b),
    .err_count(err_count_b)
  );

  function automatic logic [2:0] g_of(int b);
    logic [2:0] x;
    x = 3'(b & 7);
    return x ^ (x >> 1);
  endfunction

  // Gray to binary as the XOR of all right shifts of the word.
  function automatic int b_of(logic [2:0] g);
    int v;
    int b;
    v = int'(g);
    b = 0;
    for (int i = 0; i < 3; i++) b = b ^ (v >> i);
    return b & 7;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(bit r, bit v, logic [2:0] g);
    int b;
    int d;
    m_bv   = 0;
    m_err  = 0;
    m_wrap = 0;
    if (r) begin
      m_bin = 0; m_ref = 0; m_cnt = 0; m_cnt2 = 0;
      m_dir = 1; m_lock = 0;
    end else if (v) begin
      b     = b_of(g);
      m_bin = b;
      m_bv  = 1;
      if (!m_lock) begin
        m_lock = 1;
      end else begin
        d = (b - m_ref + 8) % 8;
        if (d == 1) begin
          m_dir  = 1;
          m_wrap = (m_ref == 7);
        end else if (d == 7) begin
          m_dir  = 0;
          m_wrap = (m_ref == 0);
        end else if (d != 0) begin
          m_err  = 1;
          m_lock = 0;
          if (m_cnt < 255) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
      m_ref = b;
    end
  endtask

  task automatic check_all();
    chk("bin_out",    32'(bin_out_a),   32'(m_bin));
    chk("bin_valid",  32'(bin_valid_a), 32'(m_bv));
    chk("dir_up",     32'(dir_up_a),    32'(m_dir));
    chk("step_err",   32'(step_err_a),  32'(m_err));
    chk("wrap_pulse", 32'(wrap_a),      32'(m_wrap));
    chk("locked",     32'(locked_a),    32'(m_lock));
    chk("err_count",  32'(err_count_a), 32'(m_cnt));
    chk("err_count_sat", 32'(err_count_b), 32'(m_cnt2));
    chk("step_err_sat",  32'(step_err_b),  32'(m_err));
    chk("locked_sat",    32'(locked_b),    32'(m_lock));
  endtask

  task automatic step_g(bit r, bit v, logic [2:0] g);
    @(negedge clk);
    rst        = r;
    gray_valid = v;
    gray_in    = g;
    @(posedge clk);
    model(r, v, g);
    #1;
    check_all();
  endtask

  task automatic step(bit r, bit v, int b);
    step_g(r, v, g_of(b));
  endtask

  initial begin
    int nb;
    int kind;
    bit r;
    bit v;

    // Reset state
    step(1, 0, 0);
    step(1, 1, 5);
    chk("reset_locked", 32'(locked_a), 32'd0);
    chk("reset_dir", 32'(dir_up_a), 32'd1);

    // Up sequence with wrap on 100 -> 000
    for (int i = 0; i <= 8; i++) step(0, 1, i % 8);

    // Down sequence 0,7,6,5
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 7);
    step(0, 1, 6);
    step(0, 1, 5);

    // Legal up to 4, then illegal jump to 0, then reacquire at 1
    step(1, 0, 0);
    for (int i = 0; i <= 3; i++) step(0, 1, i);
    step_g(0, 1, 3'b110);
    step_g(0, 1, 3'b000);
    chk("illegal_pulse", 32'(step_err_a), 32'd1);
    step_g(0, 1, 3'b001);

    // Valid low while gray_in wanders, then continue and hold
    for (int i = 0; i < 3; i++) step_g(0, 0, 3'($urandom_range(0, 7)));
    step(0, 1, 2);
    step(0, 1, 2);
    step(0, 1, 2);

    // Five illegal steps (reacquire between each)
    for (int i = 0; i < 5; i++) begin
      step(0, 1, (2 + 4 * (i + 1)) % 8);
      step(0, 1, (2 + 4 * (i + 1)) % 8);
    end
    chk("sat_count", 32'(err_count_b), 32'd3);

    // Reset mid-stream with valid high, then reacquire on 101
    step(0, 1, 3);
    step(1, 1, 4);
    step_g(0, 1, 3'b101);
    chk("reacq_bin", 32'(bin_out_a), 32'd6);

    // Random mix of mostly legal steps, holds, jumps, gaps and resets
    for (int n = 0; n < 400; n++) begin
      r    = ($urandom_range(0, 39) == 0);
      v    = ($urandom_range(0, 3) != 0);
      kind = int'($urandom_range(0, 9));
      if (kind < 4)      nb = m_ref + 1;
      else if (kind < 7) nb = m_ref + 7;
      else if (kind < 8) nb = m_ref;
      else               nb = int'($urandom_range(0, 7));
      step(r, v, nb % 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
